// File: rtl/port_input_monitor_pkg.sv
// -----------------------------------------------------------------------------
// port_input_monitor_pkg
//   Shared constants for the port-expander input stage: pin count, debounce
//   length, counter width and the PORT0/PORT1 slice positions inside the
//   16-bit {PORT1,PORT0} pin vector.
// -----------------------------------------------------------------------------
package port_input_monitor_pkg;

  localparam int WIDTH           = 16;
  localparam int DEBOUNCE_CYCLES = 50;   // 1 us at 50 MHz
  localparam int CNT_W           = 7;    // 2**CNT_W must exceed DEBOUNCE_CYCLES

  // Byte lanes of the pin vector as seen by input registers 0 and 1.
  localparam int PORT_W    = 8;
  localparam int PORT0_LSB = 0;
  localparam int PORT1_LSB = 8;

  // Terminal count: the last cycle of a run before the new level is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

endpackage : port_input_monitor_pkg

// File: rtl/port_input_monitor_pin_debounce.sv
// -----------------------------------------------------------------------------
// pin_debounce
//   One pin: 2-flop synchroniser followed by a run-length debouncer. A new
//   synchronised level is accepted once it has differed from the stable value
//   for DEBOUNCE_CYCLES consecutive clocks; any return to the stable level
//   restarts the run.
// Ports
//   clk       system clock
//   RST       asynchronous reset, active-low
//   pin_i     raw, asynchronous pin level
//   stable_o  debounced level (resets to 1, matching the pulled-up pins)
// -----------------------------------------------------------------------------
module pin_debounce
  import port_input_monitor_pkg::*;
(
  input  logic clk,
  input  logic RST,
  input  logic pin_i,
  output logic stable_o
);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours (the synchroniser depends on
  // this to stay two stages deep).
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        // Run complete: accept the level. The counter never passes CNT_LAST,
        // so it cannot wrap.
        stable_q <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign stable_o = stable_q;

endmodule : pin_debounce

// File: rtl/port_input_monitor.sv
// -----------------------------------------------------------------------------
// port_input_monitor
//   Input side of the I2C port-expander emulation. Debounces the 16 raw pins,
//   presents the stable snapshot for input registers 0/1, remembers what the
//   master last read, and drives the active-low interrupt while any
//   input-configured pin differs from that last-read value.
// Ports
//   clk          system clock
//   RST          asynchronous reset, active-low
//   pin_in       raw pin levels {PORT1,PORT0}
//   cfg_in       pin direction {r7,r6}; 1 = input, 0 = output
//   rd_port0     1-clk strobe: master read input register 0
//   rd_port1     1-clk strobe: master read input register 1
//   port_state   debounced pin levels (value of input registers 0/1)
//   change_flag  per-pin pending change, input pins only (combinational)
//   INT_N        registered interrupt, active-low
// -----------------------------------------------------------------------------
module port_input_monitor
  import port_input_monitor_pkg::*;
(
  input  logic             clk,
  input  logic             RST,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [WIDTH-1:0] cfg_in,
  input  logic             rd_port0,
  input  logic             rd_port1,
  output logic [WIDTH-1:0] port_state,
  output logic [WIDTH-1:0] change_flag,
  output logic             INT_N
);

  logic [WIDTH-1:0] last_read_q;
  logic             int_n_q;

  // Output-configured pins are debounced too, so port_state always reflects
  // the real pin level.
  for (genvar g = 0; g < WIDTH; g++) begin : g_pin
    pin_debounce u_pin_debounce (
      .clk      (clk),
      .RST      (RST),
      .pin_i    (pin_in[g]),
      .stable_o (port_state[g])
    );
  end

  // Unmasking a mismatched pin shows here at once; INT_N follows one clk later.
  assign change_flag = (port_state ^ last_read_q) & cfg_in;

  // NOTE: every register here has an async reset branch; the reset value of
  // last_read equals the reset value of port_state so no interrupt is pending
  // out of reset.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      last_read_q <= '1;
      int_n_q     <= 1'b1;
    end else begin
      // Captures the pre-edge port_state; a pin that updates on this same
      // edge therefore stays pending.
      if (rd_port0) last_read_q[PORT0_LSB +: PORT_W] <= port_state[PORT0_LSB +: PORT_W];
      if (rd_port1) last_read_q[PORT1_LSB +: PORT_W] <= port_state[PORT1_LSB +: PORT_W];
      int_n_q <= ~|change_flag;
    end
  end

  assign INT_N = int_n_q;

endmodule : port_input_monitor
